// File: rtl/rr_stream_mux.sv
// ============================================================================
//  Module      : rr_stream_mux
//  Description : N-channel valid/ready stream mux with round-robin arbitration
//                and a registered output stage. Define MUX_PKT_LOCK_EN to add
//                in_last/out_last and keep multi-beat packets contiguous.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_stream_mux #(
   parameter int N     = 4,
   parameter int WIDTH = 8,
   parameter int SELW  = $clog2(N)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [N*WIDTH-1:0]   in_data,
   input  logic [N-1:0]         in_valid,
   output logic [N-1:0]         in_ready,
`ifdef MUX_PKT_LOCK_EN
   input  logic [N-1:0]         in_last,
   output logic                 out_last,
`endif
   output logic [WIDTH-1:0]     out_data,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [SELW-1:0]      out_sel
);

   localparam logic [SELW-1:0] c_last_idx = SELW'(N - 1);

   logic [WIDTH-1:0] r_out_data;
   logic             r_out_valid;
   logic [SELW-1:0]  r_out_sel;
   logic [SELW-1:0]  r_ptr;

   logic             w_load_en;
   logic [N-1:0]     w_eligible;
   logic             w_any;
   logic             w_found_hi;
   logic [SELW-1:0]  w_grant_hi;
   logic [SELW-1:0]  w_grant_lo;
   logic [SELW-1:0]  w_grant;
   logic [SELW-1:0]  w_next_ptr;
   logic [WIDTH-1:0] w_data;
   logic [N-1:0]     w_ready;
   logic             w_xfer;

`ifdef MUX_PKT_LOCK_EN
   logic             r_lock;
   logic [SELW-1:0]  r_lock_ch;
   logic             r_out_last;
   logic [N-1:0]     w_lock_mask;

   always_comb begin
      w_lock_mask = '0;
      for (int i = 0; i < N; i++) begin
         w_lock_mask[i] = (r_lock_ch == SELW'(i));
      end
      w_eligible = r_lock ? (in_valid & w_lock_mask) : in_valid;
   end

   assign out_last = r_out_last;
`else
   always_comb begin
      w_eligible = in_valid;
   end
`endif

   // Round robin: lowest eligible index at or above ptr, else lowest overall.
   always_comb begin
      w_any      = 1'b0;
      w_found_hi = 1'b0;
      w_grant_hi = '0;
      w_grant_lo = '0;
      for (int i = N - 1; i >= 0; i--) begin
         if (w_eligible[i]) begin
            w_any      = 1'b1;
            w_grant_lo = SELW'(i);
            if (SELW'(i) >= r_ptr) begin
               w_found_hi = 1'b1;
               w_grant_hi = SELW'(i);
            end
         end
      end
      w_grant = w_found_hi ? w_grant_hi : w_grant_lo;
   end

   always_comb begin
      w_load_en  = !r_out_valid || out_ready;
      w_xfer     = w_load_en && w_any && !rst;
      w_next_ptr = (w_grant == c_last_idx) ? '0 : (w_grant + SELW'(1));
      w_data     = '0;
      w_ready    = '0;
      for (int i = 0; i < N; i++) begin
         if (w_grant == SELW'(i)) begin
            w_data     = in_data[i*WIDTH +: WIDTH];
            w_ready[i] = w_xfer;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_out_data  <= '0;
         r_out_valid <= 1'b0;
         r_out_sel   <= '0;
         r_ptr       <= '0;
`ifdef MUX_PKT_LOCK_EN
         r_lock      <= 1'b0;
         r_lock_ch   <= '0;
         r_out_last  <= 1'b0;
`endif
      end else if (w_load_en) begin
         if (w_any) begin
            r_out_data  <= w_data;
            r_out_valid <= 1'b1;
            r_out_sel   <= w_grant;
`ifdef MUX_PKT_LOCK_EN
            r_out_last  <= in_last[w_grant];
            // Pointer moves only at packet boundaries so a packet is never split.
            if (in_last[w_grant]) begin
               r_lock <= 1'b0;
               r_ptr  <= w_next_ptr;
            end else begin
               r_lock    <= 1'b1;
               r_lock_ch <= w_grant;
            end
`else
            r_ptr       <= w_next_ptr;
`endif
         end else begin
            r_out_valid <= 1'b0;
         end
      end
   end

   assign in_ready  = w_ready;
   assign out_data  = r_out_data;
   assign out_valid = r_out_valid;
   assign out_sel   = r_out_sel;

endmodule

`default_nettype wire

// File: tb/tb_rr_stream_mux.sv
// ============================================================================
//  Module      : tb_rr_stream_mux
//  Description : Directed self-checking bench for rr_stream_mux (N=4, WIDTH=8).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rr_stream_mux;

   localparam int N     = 4;
   localparam int WIDTH = 8;
   localparam int SELW  = 2;

   logic               clk = 1'b0;
   logic               rst;
   logic [N*WIDTH-1:0] in_data;
   logic [N-1:0]       in_valid;
   logic [N-1:0]       in_ready;
   logic [WIDTH-1:0]   out_data;
   logic               out_valid;
   logic               out_ready;
   logic [SELW-1:0]    out_sel;
`ifdef MUX_PKT_LOCK_EN
   logic [N-1:0]       in_last;
   logic               out_last;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   rr_stream_mux #(.N(N), .WIDTH(WIDTH)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
`ifdef MUX_PKT_LOCK_EN
      .in_last   (in_last),
      .out_last  (out_last),
`endif
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_sel   (out_sel)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_data(input logic [7:0] d0, input logic [7:0] d1,
                           input logic [7:0] d2, input logic [7:0] d3);
      in_data = {d3, d2, d1, d0};
   endtask

   task automatic check_out(input string tag, input logic v, input logic [1:0] s, input logic [7:0] d);
      check_val({tag, "_valid"}, 32'(out_valid), 32'(v));
      check_val({tag, "_sel"},   32'(out_sel),   32'(s));
      check_val({tag, "_data"},  32'(out_data),  32'(d));
   endtask

   initial begin
      logic [3:0] exp_rdy;
      logic [7:0] exp_d;

      rst       = 1'b1;
      in_valid  = 4'b1111;
      out_ready = 1'b1;
      set_data(8'hA0, 8'hA1, 8'hA2, 8'hA3);
`ifdef MUX_PKT_LOCK_EN
      in_last   = 4'b1111;
`endif

      // Reset: nothing granted even with every channel valid.
      repeat (2) begin
         step();
         check_val("rst_ready", 32'(in_ready), 32'h0);
         check_out("rst", 1'b0, 2'd0, 8'h00);
      end

      // Round robin over all four channels.
      rst = 1'b0;
      #1;
      check_val("rr_ready_first", 32'(in_ready), 32'b0001);
      for (int k = 0; k < 5; k++) begin
         step();
         exp_d = 8'hA0 + 8'(k % 4);
         check_out("rr", 1'b1, 2'(k % 4), exp_d);
         exp_rdy = 4'b0001 << ((k + 1) % 4);
         check_val("rr_ready", 32'(in_ready), 32'(exp_rdy));
      end

      // Backpressure: load 0x55 from ch1 then stall for three cycles.
      set_data(8'hA0, 8'h55, 8'hA2, 8'hA3);
      in_valid = 4'b0010;
      #1;
      check_val("bp_ready_load", 32'(in_ready), 32'b0010);
      step();
      check_out("bp_load", 1'b1, 2'd1, 8'h55);
      out_ready = 1'b0;
      in_valid  = 4'b1111;
      #1;
      check_val("bp_ready_stall", 32'(in_ready), 32'h0);
      repeat (3) begin
         step();
         check_out("bp_hold", 1'b1, 2'd1, 8'h55);
         check_val("bp_hold_ready", 32'(in_ready), 32'h0);
      end
      out_ready = 1'b1;
      #1;
      check_val("bp_release_ready", 32'(in_ready), 32'b0100);
      step();
      check_out("bp_release", 1'b1, 2'd2, 8'hA2);

      // Sparse wrap: ptr=3, only ch1 valid.
      in_valid = 4'b0010;
      #1;
      check_val("wrap_ready", 32'(in_ready), 32'b0010);
      step();
      check_out("wrap", 1'b1, 2'd1, 8'h55);
      in_valid = 4'b1111;
      #1;
      check_val("wrap_ptr2", 32'(in_ready), 32'b0100);

      // Idle drain: valid drops, sel/data hold.
      in_valid = 4'b0000;
      #1;
      check_val("idle_ready", 32'(in_ready), 32'h0);
      step();
      check_out("idle", 1'b0, 2'd1, 8'h55);

      // Reset while a beat is pending.
      in_valid = 4'b1000;
      step();
      check_out("mid_load", 1'b1, 2'd3, 8'hA3);
      out_ready = 1'b0;
      rst       = 1'b1;
      #1;
      check_val("mid_rst_ready", 32'(in_ready), 32'h0);
      step();
      check_out("mid_rst", 1'b0, 2'd0, 8'h00);
      rst       = 1'b0;
      out_ready = 1'b1;
      in_valid  = 4'b1111;
      #1;
      check_val("mid_ptr_clear", 32'(in_ready), 32'b0001);

`ifdef MUX_PKT_LOCK_EN
      // Packet lock: ch0 three beats, ch2 waiting throughout.
      set_data(8'hC0, 8'h11, 8'hC2, 8'h33);
      in_valid = 4'b0101;
      in_last  = 4'b0000;
      step();
      check_out("lk_b1", 1'b1, 2'd0, 8'hC0);
      check_val("lk_b1_last", 32'(out_last), 32'h0);
      check_val("lk_b1_ready", 32'(in_ready), 32'b0001);
      step();
      check_out("lk_b2", 1'b1, 2'd0, 8'hC0);
      check_val("lk_b2_last", 32'(out_last), 32'h0);
      in_last = 4'b0001;
      #1;
      check_val("lk_b3_ready", 32'(in_ready), 32'b0001);
      step();
      check_out("lk_b3", 1'b1, 2'd0, 8'hC0);
      check_val("lk_b3_last", 32'(out_last), 32'h1);
      in_valid = 4'b0100;
      in_last  = 4'b0100;
      #1;
      check_val("lk_ch2_ready", 32'(in_ready), 32'b0100);
      step();
      check_out("lk_ch2", 1'b1, 2'd2, 8'hC2);
      check_val("lk_ch2_last", 32'(out_last), 32'h1);
`else
      // Without lock every beat is arbitrated: ch0 and ch2 alternate.
      set_data(8'hC0, 8'h11, 8'hC2, 8'h33);
      in_valid = 4'b0101;
      step();
      check_out("alt_0", 1'b1, 2'd0, 8'hC0);
      step();
      check_out("alt_1", 1'b1, 2'd2, 8'hC2);
      step();
      check_out("alt_2", 1'b1, 2'd0, 8'hC0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
